// File: rtl/maxpool2x2_pkg.sv
// Shared definitions for the relu and pooling stages: default sample width
// and a width-agnostic signed maximum.
package maxpool2x2_pkg;

  localparam int NUM_WIDTH_DEF = 16;
  // Operands are sign-extended to this width so one function serves any sample width.
  localparam int SMAX_W        = 64;

  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                     input logic signed [SMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer holding the horizontal maxima of the even row.
// One synchronous write port, one asynchronous read port, no reset.
module pool_line_buf #(
  parameter int NUM_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int AW        = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [NUM_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [NUM_WIDTH-1:0] rdata
);

  logic [NUM_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 signed max-pool over a raster-ordered stream, with a bypass
// mode that forwards every sample. One output register, latency 1.
module maxpool2x2
  import maxpool2x2_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int ROW_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bypass,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 row_done
);

  localparam int HALF = ROW_LEN / 2;
  localparam int CW   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  function automatic logic [NUM_WIDTH-1:0] max2(input logic [NUM_WIDTH-1:0] a,
                                                input logic [NUM_WIDTH-1:0] b);
    return NUM_WIDTH'(smax(SMAX_W'(signed'(a)), SMAX_W'(signed'(b))));
  endfunction

  logic [CW-1:0]        col;
  logic                 row_odd;
  logic [NUM_WIDTH-1:0] pair;
  logic [NUM_WIDTH-1:0] lb_rdata;
  logic [AW-1:0]        lb_addr;
  logic                 accept, last_col, col_odd, lb_we, res_new;
  logic [NUM_WIDTH-1:0] pair_max;

  assign up_ready = !dn_valid || dn_ready;
  assign accept   = up_valid && up_ready;
  assign last_col = (col == CW'(ROW_LEN - 1));
  assign col_odd  = col[0];
  assign lb_addr  = AW'(col >> 1);
  assign pair_max = max2(pair, up_data);
  assign lb_we    = accept && !bypass && !row_odd && col_odd;
  assign res_new  = accept && (bypass || (row_odd && col_odd));

  pool_line_buf #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEPTH     (HALF),
    .AW        (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row_odd  <= 1'b0;
      pair     <= '0;
      dn_valid <= 1'b0;
      dn_data  <= '0;
      row_done <= 1'b0;
    end else begin
      row_done <= accept && last_col;
      if (accept) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row_odd <= ~row_odd;
      end
      // Even column: start a pair; on odd rows fold in the stored vertical partner.
      if (accept && !bypass && !col_odd)
        pair <= row_odd ? max2(lb_rdata, up_data) : up_data;
      if (res_new) begin
        dn_valid <= 1'b1;
        dn_data  <= bypass ? up_data : pair_max;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Self-checking bench for maxpool2x2 (ROW_LEN=4): directed frames plus
// randomized traffic against a frame-level reference model.
module tb_maxpool2x2;

  localparam int W = 16;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bypass = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W-1:0]  up_data = '0;
  logic          dn_valid;
  logic          dn_ready = 1'b1;
  logic [W-1:0]  dn_data;
  logic          row_done;

  maxpool2x2 #(.NUM_WIDTH(W), .ROW_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .bypass(bypass),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .row_done(row_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int q[$];
  int got_q[$];
  int xfer_acc[$];
  int xfer_cyc[$];
  int rd_log[$];
  int img [2][RL];
  int mrow, mcol, acc_cnt, cyc, hold_cycles, last_exp, held;
  bit prev_res, prev_hold, prev_last;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); got_q.delete(); xfer_acc.delete(); xfer_cyc.delete(); rd_log.delete();
      mrow = 0; mcol = 0; acc_cnt = 0; hold_cycles = 0;
      prev_res = 0; prev_hold = 0; prev_last = 0;
    end else begin
      cyc++;
      chk("up_ready", int'(up_ready), int'(!dn_valid || dn_ready));
      chk("dn_valid", int'(dn_valid), int'(prev_res || prev_hold));
      if (prev_res) chk("dn_data_latency1", $signed(dn_data), last_exp);
      else if (prev_hold) chk("dn_data_hold", $signed(dn_data), held);
      chk("row_done", int'(row_done), int'(prev_last));
      if (dn_valid && dn_ready) begin
        if (q.size() == 0) chk("extra_result", $signed(dn_data), 99999);
        else chk("scoreboard", $signed(dn_data), q.pop_front());
        got_q.push_back($signed(dn_data));
        xfer_acc.push_back(acc_cnt);
        xfer_cyc.push_back(cyc);
      end
      if (row_done) rd_log.push_back(acc_cnt);
      if (dn_valid && !dn_ready) hold_cycles++;
      prev_hold = dn_valid && !dn_ready;
      held = $signed(dn_data);
      prev_res = 0;
      prev_last = 0;
      if (up_valid && up_ready) begin
        acc_cnt++;
        img[mrow][mcol] = $signed(up_data);
        if (bypass) begin
          last_exp = $signed(up_data); q.push_back(last_exp); prev_res = 1;
        end else if (mrow == 1 && (mcol % 2) == 1) begin
          last_exp = imax(imax(img[0][mcol-1], img[0][mcol]), imax(img[1][mcol-1], img[1][mcol]));
          q.push_back(last_exp); prev_res = 1;
        end
        prev_last = (mcol == RL - 1);
        if (mcol == RL - 1) begin mcol = 0; mrow = 1 - mrow; end
        else mcol++;
      end
    end
  end

  // ---------------- dn_ready driver ----------------
  int rdy_mode = 0;  // 0 always ready, 1 random 50%, 2 stall 5 cycles after first result
  initial begin
    int stall_cnt;
    bit stall_used;
    stall_cnt = 0; stall_used = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: dn_ready = 1'($urandom_range(1));
        2: begin
          if (!stall_used && dn_valid) begin stall_cnt = 5; stall_used = 1; end
          if (stall_cnt > 0) begin dn_ready = 1'b0; stall_cnt--; end
          else dn_ready = 1'b1;
        end
        default: begin dn_ready = 1'b1; stall_used = 0; end
      endcase
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input int d, input int pct);
    int w;
    while ($urandom_range(99) >= pct) begin @(posedge clk); #1; end
    up_valid = 1'b1;
    up_data = W'(d);
    w = 0;
    @(negedge clk);
    while (!up_ready) begin
      w++;
      if (w > 1000) begin
        $display("FAIL send_timeout: up_ready stuck low, got 0 expected 1");
        $fatal(1, "stalled");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic send8(input int r0a, r0b, r0c, r0d, r1a, r1b, r1c, r1d);
    send(r0a, 100); send(r0b, 100); send(r0c, 100); send(r0d, 100);
    send(r1a, 100); send(r1b, 100); send(r1c, 100); send(r1d, 100);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || dn_valid) && w < 500) begin @(posedge clk); #1; w++; end
    chk("drain_done", int'(w < 500), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_pair(input string name, input int a, input int b);
    chk({name, "_count"}, got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk({name, "_first"}, got_q[0], a);
      chk({name, "_second"}, got_q[1], b);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #3;
    chk("rst_dn_valid", int'(dn_valid), 0);
    chk("rst_dn_data", int'(dn_data), 0);
    chk("rst_row_done", int'(row_done), 0);
    chk("rst_up_ready", int'(up_ready), 1);
    rst_n = 1'b1;

    // basic pooling with continuous flow
    do_reset();
    send8(1, 5, 2, 3, 4, 0, 7, -1);
    drain();
    chk_pair("basic", 5, 7);
    if (xfer_acc.size() == 2) begin
      chk("basic_lat_first", xfer_acc[0], 6);
      chk("basic_lat_second", xfer_acc[1], 8);
    end
    chk("basic_rowdone_count", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("basic_rowdone_a", rd_log[0], 4);
      chk("basic_rowdone_b", rd_log[1], 8);
    end

    // all-negative data exercises signed comparison
    do_reset();
    send8(-3, -2, -8, -9, -4, -5, -6, -7);
    drain();
    chk_pair("negative", -2, -6);

    // backpressure for 5 cycles after the first result
    rdy_mode = 2;
    do_reset();
    send8(1, 5, 2, 3, 4, 0, 7, -1);
    drain();
    chk_pair("stall", 5, 7);
    chk("stall_hold_cycles", hold_cycles, 5);
    rdy_mode = 0;

    // bypass, back-to-back
    bypass = 1'b1;
    do_reset();
    send(10, 100); send(20, 100); send(30, 100); send(40, 100);
    drain();
    chk("bypass_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("bypass_0", got_q[0], 10);
      chk("bypass_3", got_q[3], 40);
      chk("bypass_span", xfer_cyc[3] - xfer_cyc[0], 3);
    end
    bypass = 1'b0;

    // reset in the middle of row 1
    do_reset();
    send(1, 100); send(5, 100); send(2, 100); send(3, 100);
    send(4, 100); send(0, 100); send(7, 100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_dn_valid", int'(dn_valid), 0);
    chk("midrst_dn_data", int'(dn_data), 0);
    chk("midrst_row_done", int'(row_done), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(9, 1, 1, 1, 1, 1, 1, 2);
    drain();
    chk_pair("midrst", 9, 2);

    // randomized pooling, 64 rows
    rdy_mode = 1;
    do_reset();
    for (int i = 0; i < 64 * RL; i++) send(int'($signed(W'($urandom))), 50);
    drain();
    chk("rand_pool_count", got_q.size(), 64 * RL / 4);

    // randomized bypass, 8 rows
    bypass = 1'b1;
    do_reset();
    for (int i = 0; i < 8 * RL; i++) send(int'($signed(W'($urandom))), 50);
    drain();
    chk("rand_bypass_count", got_q.size(), 8 * RL);
    bypass = 1'b0;
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time %0t exceeded limit 2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
